// File: rtl/axi4_pkg.sv
// AXI4 address-channel types shared by the burst address generator and its users.
package axi4_pkg;

  localparam int AXI4_BOUNDARY_BYTES = 4096;
  localparam int AXI4_MAX_ADDR_WIDTH = 64;

  typedef logic [7:0] axi4_len_t;
  typedef logic [2:0] axi4_size_t;

  typedef enum logic [1:0] {
    AXI4_BURST_FIXED = 2'b00,
    AXI4_BURST_INCR  = 2'b01,
    AXI4_BURST_WRAP  = 2'b10,
    AXI4_BURST_RSVD  = 2'b11
  } axi4_burst_t;

  // id is carried on its own port because its width is a per-instance parameter
  typedef struct packed {
    logic [AXI4_MAX_ADDR_WIDTH-1:0] addr;
    axi4_len_t                      len;
    axi4_size_t                     size;
    axi4_burst_t                    burst;
  } axi4_addr_cmd_t;

  function automatic logic [7:0] axi4_size_bytes(input axi4_size_t size);
    return 8'd1 << size;
  endfunction

endpackage

// File: rtl/axi4_burst_next_addr.sv
// Combinational beat stepper: next beat address plus byte-lane masks for the
// current and next address.
module axi4_burst_next_addr
  import axi4_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_BYTES = 4
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  axi4_size_t            size,
  input  axi4_burst_t           burst,
  input  logic [ADDR_WIDTH-1:0] wrap_mask,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic [DATA_BYTES-1:0] cur_strb,
  output logic [DATA_BYTES-1:0] next_strb
);

  localparam int LANE_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

  logic [7:0]            bytes;
  logic [ADDR_WIDTH-1:0] bytes_a;
  logic [ADDR_WIDTH-1:0] aligned;

  // Lanes run from the address offset up to the end of the aligned transfer.
  function automatic logic [DATA_BYTES-1:0] lane_mask(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [7:0] nbytes);
    logic [DATA_BYTES-1:0] m;
    logic [ADDR_WIDTH-1:0] al;
    int lo;
    int hi;
    al = a & ~(ADDR_WIDTH'(nbytes) - 1'b1);
    lo = int'(a[LANE_W-1:0]) & (DATA_BYTES - 1);
    hi = (int'(al[LANE_W-1:0]) & (DATA_BYTES - 1)) + int'(nbytes) - 1;
    m  = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      m[i] = (i >= lo) && (i <= hi);
    end
    return m;
  endfunction

  always_comb begin
    bytes     = axi4_size_bytes(size);
    bytes_a   = ADDR_WIDTH'(bytes);
    aligned   = addr & ~(bytes_a - 1'b1);
    next_addr = addr;
    case (burst)
      AXI4_BURST_INCR: next_addr = aligned + bytes_a;
      AXI4_BURST_WRAP: next_addr = (addr & ~wrap_mask) | ((addr + bytes_a) & wrap_mask);
      default:         next_addr = addr;
    endcase
    cur_strb  = lane_mask(addr, bytes);
    next_strb = lane_mask(next_addr, bytes);
  end

endmodule

// File: rtl/axi4_burst_addr_gen.sv
// Expands one AXI4 AR/AW command into len+1 per-beat records (address, lanes,
// index, last, error) for the slave's data path.
//
// state    | meaning
// ST_IDLE  | no beat held, ready for a command
// ST_BURST | beat record valid, waiting for downstream handshake
module axi4_burst_addr_gen
  import axi4_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_BYTES = 4,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  axi4_len_t             cmd_len,
  input  axi4_size_t            cmd_size,
  input  axi4_burst_t           cmd_burst,
  output logic                  beat_valid,
  input  logic                  beat_ready,
  output logic [ID_WIDTH-1:0]   beat_id,
  output logic [ADDR_WIDTH-1:0] beat_addr,
  output logic [DATA_BYTES-1:0] beat_strb,
  output logic [7:0]            beat_index,
  output logic                  beat_last,
  output logic                  beat_error
);

  localparam int BOUNDARY_BITS = $clog2(AXI4_BOUNDARY_BYTES);

  typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_t;

  state_t                state;
  axi4_len_t             len_q;
  axi4_size_t            size_q;
  axi4_burst_t           burst_q;
  logic [ADDR_WIDTH-1:0] wrap_mask_q;

  logic                  accept;
  logic [7:0]            bytes_in;
  logic [ADDR_WIDTH-1:0] aligned_in;
  logic [15:0]           span_in;
  logic [15:0]           wrap_bytes_in;
  logic [ADDR_WIDTH-1:0] wrap_mask_in;
  logic                  error_in;

  logic [ADDR_WIDTH-1:0] na_addr;
  axi4_size_t            na_size;
  axi4_burst_t           na_burst;
  logic [ADDR_WIDTH-1:0] na_wrap_mask;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [DATA_BYTES-1:0] cur_strb;
  logic [DATA_BYTES-1:0] next_strb;

  assign cmd_ready = (state == ST_IDLE) || (beat_valid && beat_ready && beat_last);
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    bytes_in      = axi4_size_bytes(cmd_size);
    aligned_in    = cmd_addr & ~(ADDR_WIDTH'(bytes_in) - 1'b1);
    span_in       = (16'(cmd_len) + 16'd1) * 16'(bytes_in);
    wrap_bytes_in = span_in;
    wrap_mask_in  = ADDR_WIDTH'(wrap_bytes_in - 16'd1);
    error_in      = (cmd_burst == AXI4_BURST_RSVD)
                 || (16'(bytes_in) > 16'(DATA_BYTES))
                 || ((cmd_burst == AXI4_BURST_WRAP) &&
                     !(cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15}))
                 || ((cmd_burst == AXI4_BURST_WRAP) &&
                     ((cmd_addr & (ADDR_WIDTH'(bytes_in) - 1'b1)) != '0))
                 || ((cmd_burst == AXI4_BURST_FIXED) && (cmd_len > 8'd15))
                 || ((cmd_burst == AXI4_BURST_INCR) &&
                     ((16'(aligned_in[BOUNDARY_BITS-1:0]) + span_in) >
                      16'(AXI4_BOUNDARY_BYTES)));
  end

  // The stepper looks at the incoming command on accept, else at the held beat.
  assign na_addr      = accept ? cmd_addr     : beat_addr;
  assign na_size      = accept ? cmd_size     : size_q;
  assign na_burst     = accept ? cmd_burst    : burst_q;
  assign na_wrap_mask = accept ? wrap_mask_in : wrap_mask_q;

  axi4_burst_next_addr #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_BYTES (DATA_BYTES)
  ) u_next_addr (
    .addr      (na_addr),
    .size      (na_size),
    .burst     (na_burst),
    .wrap_mask (na_wrap_mask),
    .next_addr (next_addr),
    .cur_strb  (cur_strb),
    .next_strb (next_strb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      beat_valid  <= 1'b0;
      beat_id     <= '0;
      beat_addr   <= '0;
      beat_strb   <= '0;
      beat_index  <= '0;
      beat_last   <= 1'b0;
      beat_error  <= 1'b0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= AXI4_BURST_FIXED;
      wrap_mask_q <= '0;
    end else if (accept) begin
      state       <= ST_BURST;
      beat_valid  <= 1'b1;
      beat_id     <= cmd_id;
      beat_addr   <= cmd_addr;
      beat_strb   <= error_in ? '0 : cur_strb;
      beat_index  <= '0;
      beat_last   <= (cmd_len == 8'd0);
      beat_error  <= error_in;
      len_q       <= cmd_len;
      size_q      <= cmd_size;
      burst_q     <= cmd_burst;
      wrap_mask_q <= wrap_mask_in;
    end else if ((state == ST_BURST) && beat_ready) begin
      if (!beat_last) begin
        beat_addr  <= next_addr;
        beat_strb  <= beat_error ? '0 : next_strb;
        beat_index <= beat_index + 8'd1;
        beat_last  <= ((beat_index + 8'd1) == len_q);
      end else begin
        state      <= ST_IDLE;
        beat_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi4_burst_addr_gen.sv
// Self-checking bench: directed and random bursts against a per-beat reference
// model, checked on every falling edge.
module tb_axi4_burst_addr_gen;
  import axi4_pkg::*;

  localparam int AW = 32;
  localparam int DB = 4;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [IW-1:0] cmd_id = '0;
  logic [AW-1:0] cmd_addr = '0;
  axi4_len_t     cmd_len = '0;
  axi4_size_t    cmd_size = '0;
  axi4_burst_t   cmd_burst = AXI4_BURST_FIXED;
  logic          beat_valid;
  logic          beat_ready = 1'b1;
  logic [IW-1:0] beat_id;
  logic [AW-1:0] beat_addr;
  logic [DB-1:0] beat_strb;
  logic [7:0]    beat_index;
  logic          beat_last;
  logic          beat_error;

  int checks = 0;
  int errors = 0;
  bit rand_ready = 1'b0;

  typedef struct {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [DB-1:0] strb;
    logic [7:0]    idx;
    logic          last;
    logic          err;
  } beat_t;

  beat_t exp_q[$];
  beat_t gen_q[$];

  axi4_burst_addr_gen #(.ADDR_WIDTH(AW), .DATA_BYTES(DB), .ID_WIDTH(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_id     (cmd_id),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_size   (cmd_size),
    .cmd_burst  (cmd_burst),
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
    .beat_id    (beat_id),
    .beat_addr  (beat_addr),
    .beat_strb  (beat_strb),
    .beat_index (beat_index),
    .beat_last  (beat_last),
    .beat_error (beat_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Whole burst computed from the address/strobe/legality rules.
  function automatic void gen_beats(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                                    input int len, input int size, input int burst);
    int            bytes;
    int            wb;
    int            lo;
    int            hi;
    bit            err;
    logic [AW-1:0] a;
    logic [AW-1:0] aligned0;
    logic [AW-1:0] wmask;
    beat_t         b;
    gen_q.delete();
    bytes    = 1 << size;
    aligned0 = addr & ~AW'(bytes - 1);
    wb       = bytes * (len + 1);
    wmask    = AW'(wb - 1);
    err = (burst == 3) || (bytes > DB)
       || (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15))
       || (burst == 2 && (addr & AW'(bytes - 1)) != '0)
       || (burst == 0 && len > 15)
       || (burst == 1 && int'(aligned0[11:0]) + (len + 1) * bytes > 4096);
    a = addr;
    for (int n = 0; n <= len; n++) begin
      if (n > 0) begin
        if (burst == 1)      a = aligned0 + AW'(n * bytes);
        else if (burst == 2) a = (a & ~wmask) | ((a + AW'(bytes)) & wmask);
      end
      b.id   = id;
      b.addr = a;
      b.idx  = 8'(n);
      b.last = (n == len);
      b.err  = err;
      b.strb = '0;
      if (!err) begin
        lo = int'(a % DB);
        hi = int'((a & ~AW'(bytes - 1)) % DB) + bytes - 1;
        for (int i = 0; i < DB; i++) b.strb[i] = (i >= lo) && (i <= hi);
      end
      gen_q.push_back(b);
    end
  endfunction

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    bit exp_ready;
    if (!rst_n) begin
      exp_q.delete();
      chk("rst_beat_valid", 64'(beat_valid), 64'(0));
      chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
      chk("rst_beat_addr", 64'(beat_addr), 64'(0));
      chk("rst_beat_strb", 64'(beat_strb), 64'(0));
      chk("rst_beat_index", 64'(beat_index), 64'(0));
      chk("rst_beat_flags", 64'({beat_last, beat_error, beat_id}), 64'(0));
    end else begin
      exp_ready = (exp_q.size() == 0) || (beat_ready && exp_q.size() == 1);
      chk("cmd_ready", 64'(cmd_ready), 64'(exp_ready));
      chk("beat_valid", 64'(beat_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0 && beat_valid) begin
        chk("beat_id", 64'(beat_id), 64'(exp_q[0].id));
        chk("beat_addr", 64'(beat_addr), 64'(exp_q[0].addr));
        chk("beat_strb", 64'(beat_strb), 64'(exp_q[0].strb));
        chk("beat_index", 64'(beat_index), 64'(exp_q[0].idx));
        chk("beat_last", 64'(beat_last), 64'(exp_q[0].last));
        chk("beat_error", 64'(beat_error), 64'(exp_q[0].err));
      end
      if (beat_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (cmd_valid && exp_ready) begin
        gen_beats(cmd_id, cmd_addr, int'(cmd_len), int'(cmd_size), int'(cmd_burst));
        foreach (gen_q[i]) exp_q.push_back(gen_q[i]);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      beat_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic send_cmd(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input int len, input int size, input int burst);
    bit done;
    done = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_id    = id;
    cmd_addr  = addr;
    cmd_len   = 8'(len);
    cmd_size  = 3'(size);
    cmd_burst = axi4_burst_t'(burst);
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (cmd_ready) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL cmd_accept_timeout actual=no_accept required=accept at %0t", $time);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL idle_timeout actual=%0d required=0 beats pending", exp_q.size());
    end
  endtask

  initial begin
    int wl[4];
    bit hit;
    wl = '{1, 3, 7, 15};

    // Hand-computed pins on the model.
    gen_beats(4'h1, 32'h1002, 3, 2, 1);
    chk("pin_incr_a0", 64'(gen_q[0].addr), 64'h1002);
    chk("pin_incr_a1", 64'(gen_q[1].addr), 64'h1004);
    chk("pin_incr_a3", 64'(gen_q[3].addr), 64'h100C);
    chk("pin_incr_s0", 64'(gen_q[0].strb), 64'b1100);
    chk("pin_incr_s1", 64'(gen_q[1].strb), 64'b1111);
    chk("pin_incr_last", 64'({gen_q[3].last, gen_q[2].last, gen_q[0].err}), 64'b100);
    gen_beats(4'h2, 32'h38, 3, 2, 2);
    chk("pin_wrap_a1", 64'(gen_q[1].addr), 64'h3C);
    chk("pin_wrap_a2", 64'(gen_q[2].addr), 64'h30);
    chk("pin_wrap_a3", 64'(gen_q[3].addr), 64'h34);
    gen_beats(4'h3, 32'h21, 2, 0, 0);
    chk("pin_fixed_a2", 64'(gen_q[2].addr), 64'h21);
    chk("pin_fixed_s2", 64'(gen_q[2].strb), 64'b0010);
    gen_beats(4'h3, 32'h22, 0, 1, 0);
    chk("pin_fixed1_s", 64'({gen_q[0].last, gen_q[0].strb}), 64'b11100);
    gen_beats(4'h4, 32'h40, 2, 2, 2);
    chk("pin_wrap_len_err", 64'({gen_q[2].err, gen_q[2].strb}), 64'b10000);
    gen_beats(4'h5, 32'hFF8, 3, 2, 1);
    chk("pin_4k_err", 64'({gen_q[3].err, 4'(gen_q.size())}), 64'b10100);
    gen_beats(4'h6, 32'h100, 1, 3, 1);
    chk("pin_size_err", 64'(gen_q[0].err), 64'(1));

    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Directed bursts, downstream always ready.
    send_cmd(4'h1, 32'h1002, 3, 2, 1);
    wait_idle();
    send_cmd(4'h2, 32'h38, 3, 2, 2);
    wait_idle();
    send_cmd(4'h3, 32'h21, 2, 0, 0);
    send_cmd(4'h3, 32'h22, 0, 1, 0);
    wait_idle();
    send_cmd(4'h4, 32'h40, 2, 2, 2);
    send_cmd(4'h5, 32'hFF8, 3, 2, 1);
    send_cmd(4'h6, 32'h100, 1, 3, 1);
    wait_idle();

    // Stalls plus a queued second command.
    rand_ready = 1'b1;
    send_cmd(4'h7, 32'h200, 1, 2, 1);
    send_cmd(4'h8, 32'h300, 0, 2, 0);
    wait_idle();

    // Reset in the middle of a burst.
    rand_ready = 1'b0;
    send_cmd(4'h9, 32'h400, 7, 2, 1);
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() != 0 && exp_q[0].idx == 8'd2) hit = 1'b1;
    end
    chk("rst_mid_reached", 64'(hit), 64'(1));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_drop_valid", 64'(beat_valid), 64'(0));
    chk("rst_mid_cmd_ready", 64'(cmd_ready), 64'(1));
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    send_cmd(4'hA, 32'h500, 2, 2, 1);
    wait_idle();

    // Random commands, random stalls, back-to-back where possible.
    rand_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      axi4_addr_cmd_t c;
      int             r;
      int             sz;
      int             ln;
      int             bu;
      r  = int'($urandom_range(0, 9));
      bu = (r < 2) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
      sz = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2));
      if (bu == 2 && $urandom_range(0, 6) != 0) ln = wl[$urandom_range(0, 3)];
      else if ($urandom_range(0, 5) == 0)       ln = int'($urandom_range(16, 40));
      else                                      ln = int'($urandom_range(0, 15));
      c.addr = 64'($urandom);
      if ($urandom_range(0, 3) == 0) c.addr[11:0] = 12'hFF0 + 12'($urandom_range(0, 15));
      if (bu == 2 && $urandom_range(0, 3) != 0) c.addr = c.addr & ~64'((1 << sz) - 1);
      c.len   = 8'(ln);
      c.size  = 3'(sz);
      c.burst = axi4_burst_t'(bu);
      send_cmd(4'($urandom), c.addr[AW-1:0], int'(c.len), int'(c.size), int'(c.burst));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
